// File: rtl/fp16_pkg.sv
// fp16_pkg: shared types and constants for the half-precision add/subtract datapath
package fp16_pkg;

  localparam int FP16_MANT_W = 11;

  typedef enum logic [1:0] {
    SHIFT_LSR  = 2'b00,
    SHIFT_ASR  = 2'b01,
    SHIFT_LSL  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/shift_levels.sv
// shift_levels: combinational barrel-shifter levels for shamt bits HI..LO (sticky built with ALIGN_SHIFT_STICKY_EN)
module shift_levels
  import fp16_pkg::*;
#(
  parameter int WIDTH = FP16_MANT_W,
  parameter int HI    = 4,
  parameter int LO    = 2
) (
  input  logic [WIDTH-1:0] d_in,
  input  logic [HI-LO:0]   shamt,
  input  shift_mode_e      mode,
  input  logic             sticky_in,
  output logic [WIDTH-1:0] d_out,
  output logic             sticky_out
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic fill;

`ifdef ALIGN_SHIFT_STICKY_EN
  // apply each enabled power-of-two level; bits falling off the right end feed the sticky
  always_comb begin
    d_out = d_in;
    sticky_out = sticky_in;
    fill = 1'b0;
    for (int k = HI; k >= LO; k--) begin
      if (shamt[k-LO]) begin
        fill = (mode == SHIFT_ASR) && d_out[WIDTH-1];
        sticky_out = sticky_out | ((mode != SHIFT_LSL) && (|(d_out & ~(ONES << (1 << k)))));
        d_out = (mode == SHIFT_LSL) ? d_out << (1 << k)
              : (d_out >> (1 << k)) | ({WIDTH{fill}} & ~(ONES >> (1 << k)));
      end
    end
  end
`else
  logic unused_sticky_in;
  assign unused_sticky_in = sticky_in;
  assign sticky_out = 1'b0;

  // apply each enabled power-of-two level; shifts past the width leave only fill
  always_comb begin
    d_out = d_in;
    fill = 1'b0;
    for (int k = HI; k >= LO; k--) begin
      if (shamt[k-LO]) begin
        fill = (mode == SHIFT_ASR) && d_out[WIDTH-1];
        d_out = (mode == SHIFT_LSL) ? d_out << (1 << k)
              : (d_out >> (1 << k)) | ({WIDTH{fill}} & ~(ONES >> (1 << k)));
      end
    end
  end
`endif

endmodule

// File: rtl/align_shift_pipe.sv
// align_shift_pipe: two-stage valid/ready barrel shifter with right-shift sticky (ALIGN_SHIFT_STICKY_EN)
module align_shift_pipe
  import fp16_pkg::*;
#(
  parameter int WIDTH   = FP16_MANT_W,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky
);

  localparam int LO_W = SHAMT_W / 2;

  logic              s1_valid;
  logic [WIDTH-1:0]  s1_data;
  logic [LO_W-1:0]   s1_shamt;
  shift_mode_e       s1_mode;
  logic [WIDTH-1:0]  s1_next;
  logic [WIDTH-1:0]  s2_next;
  logic              s1_st_next;
  logic              s2_st_next;
  logic              s1_st_q;
  logic              s1_load;
  logic              s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  shift_levels #(.WIDTH(WIDTH), .HI(SHAMT_W-1), .LO(LO_W)) u_stage1 (
    .d_in       (in_data),
    .shamt      (in_shamt[SHAMT_W-1:LO_W]),
    .mode       (shift_mode_e'(in_mode)),
    .sticky_in  (1'b0),
    .d_out      (s1_next),
    .sticky_out (s1_st_next)
  );

  shift_levels #(.WIDTH(WIDTH), .HI(LO_W-1), .LO(0)) u_stage2 (
    .d_in       (s1_data),
    .shamt      (s1_shamt),
    .mode       (s1_mode),
    .sticky_in  (s1_st_q),
    .d_out      (s2_next),
    .sticky_out (s2_st_next)
  );

  // stage 1: capture the partially shifted operand whenever the stage is free or advancing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_mode  <= SHIFT_LSR;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= s1_next;
        s1_shamt <= in_shamt[LO_W-1:0];
        s1_mode  <= shift_mode_e'(in_mode);
      end
    end
  end

  // stage 2: result register, held while the consumer stalls a valid result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= s2_next;
    end
  end

`ifdef ALIGN_SHIFT_STICKY_EN
  // sticky bits travel alongside the data through both stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_st_q    <= 1'b0;
      out_sticky <= 1'b0;
    end else begin
      if (s1_load && in_valid) s1_st_q <= s1_st_next;
      if (s2_load && s1_valid) out_sticky <= s2_st_next;
    end
  end
`else
  logic unused_sticky;
  assign s1_st_q       = 1'b0;
  assign unused_sticky = s1_st_next ^ s2_st_next;
  assign out_sticky    = 1'b0;
`endif

endmodule
